// File: rtl/riscv_mem_lsu.sv
// Memory-stage load/store unit between EX and WB. It drives a req/gnt/rvalid data-memory
// port, aligns and extends data, flags misaligned or illegal accesses, and registers the WB result.
module riscv_mem_lsu #(
   parameter  int WORD_SIZE = 32,
   localparam int BE_W      = WORD_SIZE / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ex_valid_i,
   input  logic                 mem_read_i,
   input  logic                 mem_write_i,
   input  logic [2:0]           funct3_i,
   input  logic [WORD_SIZE-1:0] alu_out_i,
   input  logic [WORD_SIZE-1:0] rs2_data_i,
   input  logic [4:0]           rd_addr_i,
   input  logic                 reg_write_i,
   output logic                 stall_o,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   output logic [BE_W-1:0]      dmem_be_o,
   output logic [WORD_SIZE-1:0] dmem_addr_o,
   output logic [WORD_SIZE-1:0] dmem_wdata_o,
   input  logic                 dmem_gnt_i,
   input  logic                 dmem_rvalid_i,
   input  logic [WORD_SIZE-1:0] dmem_rdata_i,
   output logic                 wb_valid_o,
   output logic                 wb_reg_write_o,
   output logic                 wb_mem_to_reg_o,
   output logic [WORD_SIZE-1:0] wb_data_o,
   output logic [WORD_SIZE-1:0] wb_alu_out_o,
   output logic [4:0]           wb_rd_addr_o,
   output logic                 misalign_o,
   output logic [WORD_SIZE-1:0] misalign_addr_o
);

   localparam int OFF_W = $clog2(BE_W);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t               state;
   logic [OFF_W-1:0]     off;
   logic                 is_mem, illegal, misaligned, bad, go;
   logic                 req_active, complete, mem_done;
   logic [BE_W-1:0]      be_base;
   logic [WORD_SIZE-1:0] shifted, load_data;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      off        = alu_out_i[OFF_W-1:0];
      is_mem     = ex_valid_i && (mem_read_i || mem_write_i);
      illegal    = 1'b0;
      misaligned = 1'b0;
      unique case (funct3_i)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = off[0];
         3'b010:         misaligned = off[1:0] != 2'b00;
         3'b110: begin
            illegal    = WORD_SIZE != 64;
            misaligned = off[1:0] != 2'b00;
         end
         3'b011: begin
            illegal    = WORD_SIZE != 64;
            misaligned = off != '0;
         end
         default:        illegal = 1'b1;
      endcase
      bad = is_mem && (illegal || misaligned);
      go  = is_mem && !bad;
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      be_base      = '1;
      dmem_wdata_o = rs2_data_i;
      unique case (funct3_i[1:0])
         2'b00: begin
            be_base      = BE_W'(1);
            dmem_wdata_o = {BE_W{rs2_data_i[7:0]}};
         end
         2'b01: begin
            be_base      = BE_W'(3);
            dmem_wdata_o = {(BE_W/2){rs2_data_i[15:0]}};
         end
         2'b10: begin
            be_base      = BE_W'(15);
            dmem_wdata_o = {(BE_W/4){rs2_data_i[31:0]}};
         end
         default: begin
            be_base      = '1;
            dmem_wdata_o = rs2_data_i;
         end
      endcase
   end

   // Load extraction: move the addressed lane to bit 0, then extend
   always_comb begin
      shifted = dmem_rdata_i >> {off, 3'b000};
      unique case (funct3_i)
         3'b000:  load_data = WORD_SIZE'($signed(shifted[7:0]));
         3'b001:  load_data = WORD_SIZE'($signed(shifted[15:0]));
         3'b010:  load_data = WORD_SIZE'($signed(shifted[31:0]));
         3'b100:  load_data = WORD_SIZE'(shifted[7:0]);
         3'b101:  load_data = WORD_SIZE'(shifted[15:0]);
         3'b110:  load_data = WORD_SIZE'(shifted[31:0]);
         default: load_data = shifted;
      endcase
   end

   // Handshake: a grant ends a store; a load needs rvalid, which may ride along with the grant.
   always_comb begin
      mem_done   = dmem_gnt_i && (mem_write_i || dmem_rvalid_i);
      req_active = !rst_i && ((state == IDLE && go) || state == REQ);
      unique case (state)
         IDLE:    complete = (ex_valid_i && !is_mem) || bad || (go && mem_done);
         REQ:     complete = mem_done;
         RESP:    complete = dmem_rvalid_i;
         default: complete = 1'b0;
      endcase
      stall_o      = !rst_i && (state != IDLE || go) && !complete;
      dmem_req_o   = req_active;
      dmem_we_o    = req_active && mem_write_i;
      dmem_be_o    = req_active ? (be_base << off) : '0;
      dmem_addr_o  = {alu_out_i[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         wb_valid_o      <= 1'b0;
         wb_reg_write_o  <= 1'b0;
         wb_mem_to_reg_o <= 1'b0;
         wb_data_o       <= '0;
         wb_alu_out_o    <= '0;
         wb_rd_addr_o    <= '0;
         misalign_o      <= 1'b0;
         misalign_addr_o <= '0;
      end else begin
         unique case (state)
            IDLE: if (go && !mem_done) state <= dmem_gnt_i ? RESP : REQ;
            REQ:  if (dmem_gnt_i)      state <= mem_done ? IDLE : RESP;
            RESP: if (dmem_rvalid_i)   state <= IDLE;
            default:                   state <= IDLE;
         endcase
         wb_valid_o <= complete;
         misalign_o <= state == IDLE && bad;
         if (complete) begin
            wb_reg_write_o  <= reg_write_i && !bad;
            wb_mem_to_reg_o <= mem_read_i;
            wb_data_o       <= (mem_read_i && !bad) ? load_data : '0;
            wb_alu_out_o    <= alu_out_i;
            wb_rd_addr_o    <= rd_addr_i;
         end
         if (state == IDLE && bad) misalign_addr_o <= alu_out_i;
      end
   end

endmodule

// File: tb/tb_riscv_mem_lsu.sv
// Directed bench for riscv_mem_lsu: a 32-bit and a 64-bit instance driven from one
// linear sequence. Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_riscv_mem_lsu;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   stall_cnt;

   always #5 clk = ~clk;

   // 32-bit instance
   logic        ex_valid, mem_read, mem_write, reg_write, gnt, rvalid;
   logic [2:0]  funct3;
   logic [31:0] alu_out, rs2_data, rdata;
   logic [4:0]  rd_addr;
   logic        stall, req, we, wb_valid, wb_reg_write, wb_mem_to_reg, misalign;
   logic [3:0]  be;
   logic [31:0] addr, wdata, wb_data, wb_alu_out, misalign_addr;
   logic [4:0]  wb_rd_addr;

   // 64-bit instance
   logic        ex_valid_64, mem_read_64, mem_write_64, reg_write_64, gnt_64, rvalid_64;
   logic [2:0]  funct3_64;
   logic [63:0] alu_out_64, rs2_data_64, rdata_64;
   logic [4:0]  rd_addr_64;
   logic        stall_64, req_64, we_64, wb_valid_64, wb_reg_write_64, wb_mem_to_reg_64, misalign_64;
   logic [7:0]  be_64;
   logic [63:0] addr_64, wdata_64, wb_data_64, wb_alu_out_64, misalign_addr_64;
   logic [4:0]  wb_rd_addr_64;

   riscv_mem_lsu #(.WORD_SIZE(32)) dut32 (
      .clk_i(clk), .rst_i(rst),
      .ex_valid_i(ex_valid), .mem_read_i(mem_read), .mem_write_i(mem_write),
      .funct3_i(funct3), .alu_out_i(alu_out), .rs2_data_i(rs2_data),
      .rd_addr_i(rd_addr), .reg_write_i(reg_write), .stall_o(stall),
      .dmem_req_o(req), .dmem_we_o(we), .dmem_be_o(be), .dmem_addr_o(addr),
      .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
      .wb_valid_o(wb_valid), .wb_reg_write_o(wb_reg_write), .wb_mem_to_reg_o(wb_mem_to_reg),
      .wb_data_o(wb_data), .wb_alu_out_o(wb_alu_out), .wb_rd_addr_o(wb_rd_addr),
      .misalign_o(misalign), .misalign_addr_o(misalign_addr)
   );

   riscv_mem_lsu #(.WORD_SIZE(64)) dut64 (
      .clk_i(clk), .rst_i(rst),
      .ex_valid_i(ex_valid_64), .mem_read_i(mem_read_64), .mem_write_i(mem_write_64),
      .funct3_i(funct3_64), .alu_out_i(alu_out_64), .rs2_data_i(rs2_data_64),
      .rd_addr_i(rd_addr_64), .reg_write_i(reg_write_64), .stall_o(stall_64),
      .dmem_req_o(req_64), .dmem_we_o(we_64), .dmem_be_o(be_64), .dmem_addr_o(addr_64),
      .dmem_wdata_o(wdata_64), .dmem_gnt_i(gnt_64), .dmem_rvalid_i(rvalid_64),
      .dmem_rdata_i(rdata_64),
      .wb_valid_o(wb_valid_64), .wb_reg_write_o(wb_reg_write_64),
      .wb_mem_to_reg_o(wb_mem_to_reg_64), .wb_data_o(wb_data_64),
      .wb_alu_out_o(wb_alu_out_64), .wb_rd_addr_o(wb_rd_addr_64),
      .misalign_o(misalign_64), .misalign_addr_o(misalign_addr_64)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle32();
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
      funct3 = 3'b000; alu_out = '0; rs2_data = '0; rd_addr = '0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
   endtask

   task automatic idle64();
      ex_valid_64 = 1'b0; mem_read_64 = 1'b0; mem_write_64 = 1'b0; reg_write_64 = 1'b0;
      funct3_64 = 3'b000; alu_out_64 = '0; rs2_data_64 = '0; rd_addr_64 = '0;
      gnt_64 = 1'b0; rvalid_64 = 1'b0; rdata_64 = '0;
   endtask

   task automatic op32(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw);
      ex_valid = 1'b1; mem_read = rd_en; mem_write = wr_en; funct3 = f3;
      alu_out = a; rs2_data = d; rd_addr = rd; reg_write = rw;
   endtask

   task automatic op64(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d,
                       input logic [4:0] rd, input logic rw);
      ex_valid_64 = 1'b1; mem_read_64 = rd_en; mem_write_64 = wr_en; funct3_64 = f3;
      alu_out_64 = a; rs2_data_64 = d; rd_addr_64 = rd; reg_write_64 = rw;
   endtask

   initial begin
      rst = 1'b1;
      idle32();
      idle64();
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall", stall, 1'b0);
      check("rst_req", req, 1'b0);
      check("rst_we", we, 1'b0);
      check("rst_be", be, 4'h0);
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_wb_reg_write", wb_reg_write, 1'b0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_misalign", misalign, 1'b0);
      check("rst_misalign_addr", misalign_addr, 32'h0);
      check("rst64_wb_valid", wb_valid_64, 1'b0);
      check("rst64_be", be_64, 8'h00);

      // ALU pass-through
      @(negedge clk); rst = 1'b0;
      op32(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
      #1;
      check("alu_stall", stall, 1'b0);
      check("alu_req", req, 1'b0);
      @(negedge clk); idle32(); #1;
      check("alu_wb_valid", wb_valid, 1'b1);
      check("alu_wb_alu_out", wb_alu_out, 32'h1234);
      check("alu_wb_rd", wb_rd_addr, 5'd5);
      check("alu_wb_reg_write", wb_reg_write, 1'b1);
      check("alu_wb_mem_to_reg", wb_mem_to_reg, 1'b0);

      // SB at 0x1003 with same-cycle grant
      @(negedge clk);
      op32(1'b0, 1'b1, 3'b000, 32'h1003, 32'hAB, 5'd0, 1'b0);
      gnt = 1'b1;
      #1;
      check("sb_wb_valid_idle", wb_valid, 1'b0);
      check("sb_req", req, 1'b1);
      check("sb_we", we, 1'b1);
      check("sb_addr", addr, 32'h1000);
      check("sb_be", be, 4'b1000);
      check("sb_wdata", wdata, 32'hABAB_ABAB);
      check("sb_stall", stall, 1'b0);
      @(negedge clk); idle32(); #1;
      check("sb_wb_valid", wb_valid, 1'b1);
      check("sb_wb_reg_write", wb_reg_write, 1'b0);

      // LH at 0x2002: grant in the third cycle, rvalid after three more
      stall_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         op32(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 5'd7, 1'b1);
         gnt    = (i == 2);
         rvalid = (i == 6);
         rdata  = (i == 6) ? 32'h8001_0000 : 32'h0;
         #1;
         if (stall) stall_cnt++;
         if (i == 0) begin
            check("lh_req", req, 1'b1);
            check("lh_addr", addr, 32'h2000);
            check("lh_be", be, 4'b1100);
         end
         if (i == 4) begin
            check("lh_resp_req", req, 1'b0);
            check("lh_wait_wb_valid", wb_valid, 1'b0);
         end
      end
      check("lh_stall_cycles", stall_cnt, 6);

      // LHU back-to-back with zero-latency memory
      @(negedge clk);
      op32(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 5'd8, 1'b1);
      gnt = 1'b1; rvalid = 1'b1; rdata = 32'h8001_0000;
      #1;
      check("lh_wb_valid", wb_valid, 1'b1);
      check("lh_wb_data", wb_data, 32'hFFFF_8001);
      check("lh_wb_mem_to_reg", wb_mem_to_reg, 1'b1);
      check("lh_wb_rd", wb_rd_addr, 5'd7);
      check("lhu_stall", stall, 1'b0);
      @(negedge clk); idle32(); #1;
      check("lhu_wb_valid", wb_valid, 1'b1);
      check("lhu_wb_data", wb_data, 32'h0000_8001);
      check("lhu_wb_rd", wb_rd_addr, 5'd8);

      // LB at 0x4001: granted at once, data one cycle later
      @(negedge clk);
      op32(1'b1, 1'b0, 3'b000, 32'h4001, 32'h0, 5'd9, 1'b1);
      gnt = 1'b1;
      #1;
      check("lb_stall_gnt", stall, 1'b1);
      check("lb_be", be, 4'b0010);
      @(negedge clk);
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_8000;
      #1;
      check("lb_stall_rvalid", stall, 1'b0);
      check("lb_resp_req", req, 1'b0);
      @(negedge clk); idle32(); #1;
      check("lb_wb_data", wb_data, 32'hFFFF_FF80);

      // Stray grant/rvalid in IDLE are ignored
      @(negedge clk);
      gnt = 1'b1; rvalid = 1'b1;
      #1;
      check("stray_stall", stall, 1'b0);
      check("stray_req", req, 1'b0);
      @(negedge clk); idle32(); #1;
      check("stray_wb_valid", wb_valid, 1'b0);

      // Misaligned LW at 0x3001
      @(negedge clk);
      op32(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 5'd10, 1'b1);
      #1;
      check("mis_req", req, 1'b0);
      check("mis_stall", stall, 1'b0);
      @(negedge clk); idle32(); #1;
      check("mis_wb_valid", wb_valid, 1'b1);
      check("mis_pulse", misalign, 1'b1);
      check("mis_addr", misalign_addr, 32'h3001);
      check("mis_wb_reg_write", wb_reg_write, 1'b0);
      @(negedge clk); #1;
      check("mis_pulse_end", misalign, 1'b0);
      check("mis_addr_hold", misalign_addr, 32'h3001);

      // LD is illegal on the 32-bit datapath
      @(negedge clk);
      op32(1'b1, 1'b0, 3'b011, 32'h8, 32'h0, 5'd3, 1'b1);
      #1;
      check("ld32_req", req, 1'b0);
      @(negedge clk); idle32(); #1;
      check("ld32_misalign", misalign, 1'b1);
      check("ld32_misalign_addr", misalign_addr, 32'h8);

      // Reset while a granted load waits for rvalid
      @(negedge clk);
      op32(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 5'd11, 1'b1);
      gnt = 1'b1;
      #1;
      check("rstmid_stall", stall, 1'b1);
      @(negedge clk);
      rst = 1'b1; idle32();
      #1;
      check("rstmid_req_in_reset", req, 1'b0);
      @(negedge clk);
      rst = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
      #1;
      check("rstmid_stall_after", stall, 1'b0);
      check("rstmid_wb_valid", wb_valid, 1'b0);
      check("rstmid_misalign_addr", misalign_addr, 32'h0);
      check("rstmid_wb_alu_out", wb_alu_out, 32'h0);
      @(negedge clk); rvalid = 1'b0; #1;
      check("rstmid_late_rvalid", wb_valid, 1'b0);

      // 64-bit datapath: LD, LWU, SW
      @(negedge clk);
      op64(1'b1, 1'b0, 3'b011, 64'h8, 64'h0, 5'd12, 1'b1);
      gnt_64 = 1'b1; rvalid_64 = 1'b1; rdata_64 = 64'h8000_0000_0000_0001;
      #1;
      check("ld64_be", be_64, 8'hFF);
      check("ld64_addr", addr_64, 64'h8);
      check("ld64_stall", stall_64, 1'b0);
      @(negedge clk);
      op64(1'b1, 1'b0, 3'b110, 64'hC, 64'h0, 5'd13, 1'b1);
      rdata_64 = 64'h8000_0000_0000_0000;
      #1;
      check("ld64_wb_data", wb_data_64, 64'h8000_0000_0000_0001);
      check("lwu64_be", be_64, 8'hF0);
      check("lwu64_addr", addr_64, 64'h8);
      @(negedge clk);
      op64(1'b0, 1'b1, 3'b010, 64'h4, 64'h1122_3344, 5'd0, 1'b0);
      rvalid_64 = 1'b0;
      #1;
      check("lwu64_wb_data", wb_data_64, 64'h0000_0000_8000_0000);
      check("sw64_wdata", wdata_64, 64'h1122_3344_1122_3344);
      check("sw64_be", be_64, 8'hF0);
      check("sw64_addr", addr_64, 64'h0);
      @(negedge clk); idle64(); #1;
      check("sw64_wb_valid", wb_valid_64, 1'b1);
      check("sw64_wb_mem_to_reg", wb_mem_to_reg_64, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
